// File: rtl/ldpc_check_message_expander.sv
// ldpc_check_message_expander
//   Check-node output stage of the min-sum LDPC decoder. Accepts one
//   compressed check-node record (min1, min2, one-hot min location, per-edge
//   sign bits, degree) per handshake. It then streams one signed extrinsic
//   message per active edge, serially, with valid/ready flow control.
//
//   Optional feature (macro LDPC_OFFSET_EN): offset-min-sum. When the macro
//   is defined, each magnitude becomes max(mag - OFFSET, 0) before the sign
//   is applied. When it is undefined, magnitudes pass through unchanged and
//   OFFSET has no effect.
//
// Ports
//   i_clock        clock, rising edge
//   i_reset_n      asynchronous active-low reset
//   i_min1/i_min2  smallest / second-smallest unsigned magnitude
//   i_min_location one-hot edge index of min1 (lowest set bit wins)
//   i_signs        per-edge input sign bits, 1 = negative
//   i_degree       active edge count (0 = empty record, 9..15 act as 8)
//   i_valid/o_ready record handshake
//   o_msg          signed WIDTH+1 extrinsic message
//   o_edge         edge index of o_msg
//   o_last         final edge of the record
//   o_valid/i_ready output beat handshake
module ldpc_check_message_expander #(
  parameter int WIDTH  = 16,
  parameter int OFFSET = 1
) (
  input  logic                    i_clock,
  input  logic                    i_reset_n,
  input  logic [WIDTH-1:0]        i_min1,
  input  logic [WIDTH-1:0]        i_min2,
  input  logic [7:0]              i_min_location,
  input  logic [7:0]              i_signs,
  input  logic [3:0]              i_degree,
  input  logic                    i_valid,
  output logic                    o_ready,
  output logic signed [WIDTH:0]   o_msg,
  output logic [2:0]              o_edge,
  output logic                    o_last,
  output logic                    o_valid,
  input  logic                    i_ready
);

  typedef enum logic {IDLE, EMIT} state_t;

  // Unsigned subtraction of OFFSET that saturates at zero.
  function automatic logic [WIDTH-1:0] sat_sub_offset(input logic [WIDTH-1:0] m);
    logic [WIDTH-1:0] off;
    off = OFFSET[WIDTH-1:0];
    return (m > off) ? (m - off) : '0;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       edge_q, edge_d;

  logic [WIDTH-1:0] min1_q, min1_d;
  logic [WIDTH-1:0] min2_q, min2_d;
  logic [7:0]       signs_q, signs_d;
  logic [3:0]       deg_q, deg_d;
  logic             parity_q, parity_d;
  logic [2:0]       min_idx_q, min_idx_d;
  logic             min_hit_q, min_hit_d;

  logic [3:0]       deg_clamp;
  logic             in_parity;
  logic [2:0]       loc_idx;
  logic             loc_any;
  logic             loc_hit;
  logic             last_beat;
  logic             accept;
  logic             start;

  logic [WIDTH-1:0]      mag_sel;
  logic [WIDTH-1:0]      mag_adj;
  logic                  msg_sign;
  logic signed [WIDTH:0] mag_s;
  logic signed [WIDTH:0] msg;

  // Input record decode: clamp degree, fold signs, locate the min edge.
  always_comb begin
    deg_clamp = (i_degree > 4'd8) ? 4'd8 : i_degree;
    in_parity = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < deg_clamp) in_parity = in_parity ^ i_signs[k];
    end
    // Scan downward so the lowest set bit is the one that sticks.
    loc_idx = '0;
    loc_any = 1'b0;
    for (int k = 7; k >= 0; k--) begin
      if (i_min_location[k]) begin
        loc_idx = 3'(k);
        loc_any = 1'b1;
      end
    end
    // A min location outside the active edges means no edge takes min2.
    loc_hit = loc_any && ({1'b0, loc_idx} < deg_clamp);
  end

  // Handshake and state sequencing.
  always_comb begin
    last_beat = (state_q == EMIT) && ({1'b0, edge_q} == (deg_q - 4'd1));
    // During the final beat a new record may be taken in the same cycle the
    // beat leaves, which is what removes the bubble between records.
    o_ready   = (state_q == IDLE) || (last_beat && i_ready);
    accept    = i_valid && o_ready;
    start     = accept && (deg_clamp != 4'd0);

    state_d = state_q;
    edge_d  = edge_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = EMIT;
          edge_d  = '0;
        end
      end
      EMIT: begin
        if (i_ready) begin
          if (!last_beat) begin
            edge_d = edge_q + 3'd1;
          end else if (start) begin
            edge_d = '0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    min1_d    = min1_q;
    min2_d    = min2_q;
    signs_d   = signs_q;
    deg_d     = deg_q;
    parity_d  = parity_q;
    min_idx_d = min_idx_q;
    min_hit_d = min_hit_q;
    if (accept) begin
      min1_d    = i_min1;
      min2_d    = i_min2;
      signs_d   = i_signs;
      deg_d     = deg_clamp;
      parity_d  = in_parity;
      min_idx_d = loc_idx;
      min_hit_d = loc_hit;
    end
  end

  // Control state: the only flops that reset.
  always_ff @(posedge i_clock or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      edge_q  <= '0;
    end else begin
      state_q <= state_d;
      edge_q  <= edge_d;
    end
  end

  // Record holding registers; only read while in EMIT.
  always_ff @(posedge i_clock) begin
    min1_q    <= min1_d;
    min2_q    <= min2_d;
    signs_q   <= signs_d;
    deg_q     <= deg_d;
    parity_q  <= parity_d;
    min_idx_q <= min_idx_d;
    min_hit_q <= min_hit_d;
  end

  // Per-edge message expansion from the held record.
  always_comb begin
    mag_sel = (min_hit_q && (edge_q == min_idx_q)) ? min2_q : min1_q;
`ifdef LDPC_OFFSET_EN
    mag_adj = sat_sub_offset(mag_sel);
`else
    mag_adj = mag_sel;
`endif
    // Extrinsic sign excludes the edge's own sign from the record parity.
    msg_sign = parity_q ^ signs_q[edge_q];
    mag_s    = $signed({1'b0, mag_adj});
    // Negating a zero magnitude gives zero, so there is no negative zero.
    msg      = msg_sign ? -mag_s : mag_s;
  end

  // Outputs are forced to zero outside EMIT so the unreset record registers
  // never show up on the ports.
  always_comb begin
    o_valid = (state_q == EMIT);
    o_msg   = o_valid ? msg : '0;
    o_edge  = o_valid ? edge_q : 3'd0;
    o_last  = last_beat;
  end

endmodule

// File: tb/tb_ldpc_check_message_expander.sv
module tb_ldpc_check_message_expander;

  localparam int WIDTH  = 16;
  localparam int OFFSET = 1;

  logic                  clk;
  logic                  rst_n;
  logic [WIDTH-1:0]      i_min1;
  logic [WIDTH-1:0]      i_min2;
  logic [7:0]            i_min_location;
  logic [7:0]            i_signs;
  logic [3:0]            i_degree;
  logic                  i_valid;
  logic                  o_ready;
  logic signed [WIDTH:0] o_msg;
  logic [2:0]            o_edge;
  logic                  o_last;
  logic                  o_valid;
  logic                  i_ready;

  ldpc_check_message_expander #(.WIDTH(WIDTH), .OFFSET(OFFSET)) dut (
    .i_clock        (clk),
    .i_reset_n      (rst_n),
    .i_min1         (i_min1),
    .i_min2         (i_min2),
    .i_min_location (i_min_location),
    .i_signs        (i_signs),
    .i_degree       (i_degree),
    .i_valid        (i_valid),
    .o_ready        (o_ready),
    .o_msg          (o_msg),
    .o_edge         (o_edge),
    .o_last         (o_last),
    .o_valid        (o_valid),
    .i_ready        (i_ready)
  );

  typedef struct {
    logic signed [WIDTH:0] msg;
    logic [2:0]            edge_idx;
    logic                  last;
  } beat_t;

  beat_t exp_q[$];
  int    n_cmp = 0;
  int    n_err = 0;
  int    rdy_mode = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: expand one record into its list of expected beats.
  task automatic model_push(input int min1, input int min2, input logic [7:0] loc,
                            input logic [7:0] signs, input int deg);
    int    dc;
    int    par;
    int    me;
    int    mag;
    int    v;
    beat_t b;
    dc  = (deg > 8) ? 8 : deg;
    par = 0;
    for (int k = 0; k < dc; k++) par = par ^ int'(signs[k]);
    me = -1;
    for (int k = 7; k >= 0; k--) if (loc[k]) me = k;
    if (me >= dc) me = -1;
    for (int k = 0; k < dc; k++) begin
      mag = (k == me) ? min2 : min1;
`ifdef LDPC_OFFSET_EN
      mag = mag - OFFSET;
      if (mag < 0) mag = 0;
`endif
      v = ((par ^ int'(signs[k])) != 0) ? -mag : mag;
      b.msg      = v[WIDTH:0];
      b.edge_idx = k[2:0];
      b.last     = (k == dc - 1);
      exp_q.push_back(b);
    end
  endtask

  // Downstream ready generator, changes just after each rising edge.
  initial begin
    i_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        0:       i_ready = 1'b1;
        1:       i_ready = ~i_ready;
        default: i_ready = ($urandom_range(0, 3) != 0);
      endcase
    end
  end

  // Monitor: scoreboard, stall stability, handshake and latency checks.
  logic                  acc_pend = 1'b0;
  logic                  acc_nz = 1'b0;
  logic                  stall_pend = 1'b0;
  logic signed [WIDTH:0] prev_msg;
  logic [2:0]            prev_edge;
  logic                  prev_last;

  always @(negedge clk) begin
    beat_t b;
    if (!rst_n) begin
      acc_pend   = 1'b0;
      stall_pend = 1'b0;
    end else begin
      if (acc_pend) begin
        check("first_beat_valid", o_valid, acc_nz);
        if (acc_nz) check("first_beat_edge", o_edge, 0);
      end
      if (stall_pend) begin
        check("stall_valid", o_valid, 1);
        check("stall_msg", $unsigned(o_msg), $unsigned(prev_msg));
        check("stall_edge", o_edge, prev_edge);
        check("stall_last", o_last, prev_last);
      end
      check("o_ready", o_ready, (!o_valid) || (o_last && i_ready));
      if (o_valid && i_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          b = exp_q.pop_front();
          check("msg", $unsigned(o_msg), $unsigned(b.msg));
          check("edge", o_edge, b.edge_idx);
          check("last", o_last, b.last);
        end
      end
      acc_pend = i_valid && o_ready;
      acc_nz   = (i_degree != 4'd0);
      if (acc_pend) model_push(int'(i_min1), int'(i_min2), i_min_location, i_signs, int'(i_degree));
      stall_pend = o_valid && !i_ready;
      prev_msg   = o_msg;
      prev_edge  = o_edge;
      prev_last  = o_last;
    end
  end

  // Present a record and hold it until the DUT takes it.
  task automatic send(input int min1, input int min2, input logic [7:0] loc,
                      input logic [7:0] signs, input int deg);
    logic got;
    int   t;
    i_min1         = min1[WIDTH-1:0];
    i_min2         = min2[WIDTH-1:0];
    i_min_location = loc;
    i_signs        = signs;
    i_degree       = deg[3:0];
    i_valid        = 1'b1;
    got = 1'b0;
    t   = 0;
    while (!got && t < 200) begin
      @(negedge clk);
      if (o_ready) got = 1'b1;
      @(posedge clk);
      #1;
      t++;
    end
    if (!got) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (exp_q.size() != 0 && t < 2000) begin
      @(posedge clk);
      t++;
    end
    check("drain_remaining", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  initial begin
    int gap;
    int m1, m2, dg;
    logic [7:0] lc;
    logic [7:0] sg;

    rst_n          = 1'b0;
    i_valid        = 1'b0;
    i_min1         = '0;
    i_min2         = '0;
    i_min_location = '0;
    i_signs        = '0;
    i_degree       = '0;
    #3;
    check("rst_valid", o_valid, 0);
    check("rst_msg", $unsigned(o_msg), 0);
    check("rst_edge", o_edge, 0);
    check("rst_last", o_last, 0);
    check("rst_ready", o_ready, 1);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Basic records with different sign patterns.
    send(5, 9, 8'h04, 8'h00, 4);
    @(negedge clk);
    check("lat_valid", o_valid, 1);
    drain();
    send(5, 9, 8'h04, 8'h03, 4);
    drain();
    send(5, 9, 8'h04, 8'h01, 4);
    drain();

    // Back-to-back records, no gap.
    send(12, 30, 8'h02, 8'hA5, 3);
    send(7, 8, 8'h01, 8'h0F, 5);
    send(1, 2, 8'h80, 8'hFF, 8);
    drain();

    // Ready toggling during a full-degree record.
    rdy_mode = 1;
    send(100, 200, 8'h10, 8'h5A, 8);
    drain();
    rdy_mode = 0;

    // Degree and location anomalies, zero magnitudes.
    send(3, 4, 8'h01, 8'h00, 0);
    send(9, 11, 8'h08, 8'hC3, 12);
    drain();
    send(21, 22, 8'h00, 8'h3C, 6);
    drain();
    send(21, 22, 8'h50, 8'h00, 8);
    drain();
    send(21, 22, 8'h40, 8'h00, 4);
    drain();
    send(0, 3, 8'h02, 8'h06, 4);
    drain();
    send(65535, 65535, 8'h01, 8'h01, 2);
    drain();

    // Reset in the middle of a record discards it.
    send(7, 11, 8'h01, 8'h55, 8);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_valid", o_valid, 0);
    check("midrst_ready", o_ready, 1);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    check("postrst_ready", o_ready, 1);
    check("postrst_valid", o_valid, 0);
    @(posedge clk);
    #1;

    // Randomized records with random downstream backpressure.
    rdy_mode = 2;
    for (int n = 0; n < 120; n++) begin
      case ($urandom_range(0, 3))
        0:       m1 = 0;
        1:       m1 = 65535;
        default: m1 = int'($urandom_range(0, 65535));
      endcase
      case ($urandom_range(0, 3))
        0:       m2 = 0;
        1:       m2 = 65535;
        default: m2 = int'($urandom_range(0, 65535));
      endcase
      dg = ($urandom_range(0, 4) == 0) ? int'($urandom_range(0, 15)) : int'($urandom_range(1, 8));
      lc = ($urandom_range(0, 1) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'($urandom);
      sg = 8'($urandom);
      send(m1, m2, lc, sg, dg);
      gap = int'($urandom_range(0, 3));
      if (gap > 1) repeat (gap - 1) @(posedge clk);
      #1;
    end
    drain();
    rdy_mode = 0;
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
